// File: rtl/mem_arb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_ctrl_pkg
// Shared definitions for the memory arbiter/controller:
//   - state_e        : 2-bit FSM state encoding (IDLE, WR, RD1, RD2)
//   - DEF_DATA_WIDTH : default RAM word width
//   - DEF_ADDR_WIDTH : default RAM address width
// ---------------------------------------------------------------------------
package mem_arb_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_RD1  = 2'd2,
        ST_RD2  = 2'd3
    } state_e;

endpackage : mem_arb_ctrl_pkg

// File: rtl/mem_arb_ctrl.sv
// ---------------------------------------------------------------------------
// mem_arb_ctrl
// Arbitrates a single-port-write / dual-port-read RAM between a loader
// (writes) and a compute engine (dual reads). Round-robin grant in IDLE,
// a write occupies WR for one cycle, a read walks RD1 -> RD2 and the RAM
// outputs are captured at the end of RD2.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   wr_req/wr_addr/wr_data: write request and operands; wr_gnt pulse
//   rd_req/rd_addr_a/b    : dual-read request and addresses; rd_gnt pulse
//   rd_valid/rd_data_a/b  : read result pulse and held read data
//   busy                  : FSM not in IDLE
//   ram_*                 : RAM controls, addresses, write data, read data
// ---------------------------------------------------------------------------
module mem_arb_ctrl
    import mem_arb_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_gnt,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data_a,
    output logic [DATA_WIDTH-1:0] rd_data_b,
    output logic                  busy,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe_a,
    output logic                  ram_oe_b,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout_a,
    input  logic [DATA_WIDTH-1:0] ram_dout_b
);

    state_e                state_q, state_d;
    // 1: the read side was granted last, so a tie goes to the write side
    logic                  last_rd_q, last_rd_d;
    logic [ADDR_WIDTH-1:0] op_addr_a_q, op_addr_a_d;
    logic [ADDR_WIDTH-1:0] op_addr_b_q, op_addr_b_d;
    logic [DATA_WIDTH-1:0] op_data_q, op_data_d;
    logic [DATA_WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic                  rd_valid_q, rd_valid_d;

    // Next-state, round-robin grant, operand latching and read capture
    always_comb begin
        state_d     = state_q;
        last_rd_d   = last_rd_q;
        op_addr_a_d = op_addr_a_q;
        op_addr_b_d = op_addr_b_q;
        op_data_d   = op_data_q;
        rd_data_a_d = rd_data_a_q;
        rd_data_b_d = rd_data_b_q;
        rd_valid_d  = 1'b0;
        wr_gnt      = 1'b0;
        rd_gnt      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rst) begin
                    // no grant may be issued while reset is applied
                    state_d = ST_IDLE;
                end else if (wr_req && (!rd_req || last_rd_q)) begin
                    wr_gnt      = 1'b1;
                    last_rd_d   = 1'b0;
                    op_addr_a_d = wr_addr;
                    op_addr_b_d = '0;
                    op_data_d   = wr_data;
                    state_d     = ST_WR;
                end else if (rd_req) begin
                    rd_gnt      = 1'b1;
                    last_rd_d   = 1'b1;
                    op_addr_a_d = rd_addr_a;
                    op_addr_b_d = rd_addr_b;
                    op_data_d   = '0;
                    state_d     = ST_RD1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_RD1: begin
                state_d = ST_RD2;
            end
            ST_RD2: begin
                // RAM data has had RD1 and RD2 to settle; capture at this edge
                rd_data_a_d = ram_dout_a;
                rd_data_b_d = ram_dout_b;
                rd_valid_d  = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // RAM control decode from the registered state and operand registers only
    always_comb begin
        ram_cs     = 1'b0;
        ram_we     = 1'b0;
        ram_oe_a   = 1'b0;
        ram_oe_b   = 1'b0;
        ram_addr_a = '0;
        ram_addr_b = '0;
        ram_din    = '0;

        case (state_q)
            ST_WR: begin
                ram_cs     = 1'b1;
                ram_we     = 1'b1;
                ram_addr_a = op_addr_a_q;
                ram_din    = op_data_q;
            end
            ST_RD1, ST_RD2: begin
                ram_cs     = 1'b1;
                ram_oe_a   = 1'b1;
                ram_oe_b   = 1'b1;
                ram_addr_a = op_addr_a_q;
                ram_addr_b = op_addr_b_q;
            end
            default: begin
                ram_cs = 1'b0;
            end
        endcase
    end

    // State and data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_rd_q   <= 1'b1;
            op_addr_a_q <= '0;
            op_addr_b_q <= '0;
            op_data_q   <= '0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_rd_q   <= last_rd_d;
            op_addr_a_q <= op_addr_a_d;
            op_addr_b_q <= op_addr_b_d;
            op_data_q   <= op_data_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign busy      = (state_q != ST_IDLE);

endmodule : mem_arb_ctrl
